// File: rtl/alu_pkg.sv
// Shared constants for the ALU command sequencer and its benches:
// widths, opcode values and FSM state encoding.
package alu_pkg;

  localparam int DW   = 3;
  localparam int OPW  = 2;
  localparam int RW   = 5;
  localparam int CNTW = 8;

  localparam logic [OPW-1:0] OP_ADD = 2'd0;
  localparam logic [OPW-1:0] OP_SUB = 2'd1;
  localparam logic [OPW-1:0] OP_AND = 2'd2;
  localparam logic [OPW-1:0] OP_OR  = 2'd3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_GET_A = 3'd1;
  localparam logic [2:0] ST_GET_B = 3'd2;
  localparam logic [2:0] ST_EXEC  = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  typedef enum logic [2:0] {
    SEQ_IDLE  = ST_IDLE,
    SEQ_GET_A = ST_GET_A,
    SEQ_GET_B = ST_GET_B,
    SEQ_EXEC  = ST_EXEC,
    SEQ_RESP  = ST_RESP
  } seq_state_e;

  // States in which a serial beat can be taken.
  function automatic logic accepts_beat(input seq_state_e st);
    return (st == SEQ_IDLE) || (st == SEQ_GET_A) || (st == SEQ_GET_B);
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Serial command front-end for the combinational ALU: collects opcode/A/B
// beats, holds operands on the ALU, captures the answer onto a result port.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DW   = alu_pkg::DW,
  parameter int OPW  = alu_pkg::OPW,
  parameter int RW   = alu_pkg::RW,
  parameter int CNTW = alu_pkg::CNTW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  input  logic            abort,
  output logic [OPW-1:0]  alu_s,
  output logic [DW-1:0]   alu_a,
  output logic [DW-1:0]   alu_b,
  input  logic [RW-1:0]   alu_ans,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [RW-1:0]   res_data,
  output logic [OPW-1:0]  res_op,
  output logic            busy,
  output logic [CNTW-1:0] op_cnt
);

  seq_state_e      state_q;
  logic [OPW-1:0]  alu_s_q;
  logic [DW-1:0]   alu_a_q;
  logic [DW-1:0]   alu_b_q;
  logic            res_valid_q;
  logic [RW-1:0]   res_data_q;
  logic [OPW-1:0]  res_op_q;
  logic [CNTW-1:0] op_cnt_q;

  logic beat;
  logic unused_in_hi;

  assign beat         = in_valid && accepts_beat(state_q);
  // The opcode beat only carries OPW meaningful bits.
  assign unused_in_hi = ^in_data[DW-1:OPW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SEQ_IDLE;
      alu_s_q     <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_op_q    <= '0;
      op_cnt_q    <= '0;
    end else if (abort) begin
      // Flush: operands stay on the ALU, any offered beat is dropped.
      state_q     <= SEQ_IDLE;
      res_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        SEQ_IDLE: begin
          if (beat) begin
            alu_s_q <= in_data[OPW-1:0];
            state_q <= SEQ_GET_A;
          end
        end
        SEQ_GET_A: begin
          if (beat) begin
            alu_a_q <= in_data;
            state_q <= SEQ_GET_B;
          end
        end
        SEQ_GET_B: begin
          if (beat) begin
            alu_b_q <= in_data;
            state_q <= SEQ_EXEC;
          end
        end
        SEQ_EXEC: begin
          res_data_q  <= alu_ans;
          res_op_q    <= alu_s_q;
          res_valid_q <= 1'b1;
          state_q     <= SEQ_RESP;
        end
        SEQ_RESP: begin
          if (res_valid_q && res_ready) begin
            res_valid_q <= 1'b0;
            op_cnt_q    <= op_cnt_q + 1'b1;
            state_q     <= SEQ_IDLE;
          end
        end
        default: state_q <= SEQ_IDLE;
      endcase
    end
  end

  assign in_ready  = accepts_beat(state_q);
  assign busy      = (state_q != SEQ_IDLE);
  assign alu_s     = alu_s_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_op    = res_op_q;
  assign op_cnt    = op_cnt_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer with a behavioural 2-bit-select ALU attached;
// results are checked against a queue of expected {opcode, answer} pairs.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic            abort;
  logic [OPW-1:0]  alu_s;
  logic [DW-1:0]   alu_a;
  logic [DW-1:0]   alu_b;
  logic [RW-1:0]   alu_ans;
  logic            res_valid;
  logic            res_ready;
  logic [RW-1:0]   res_data;
  logic [OPW-1:0]  res_op;
  logic            busy;
  logic [CNTW-1:0] op_cnt;

  alu_cmd_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .abort     (abort),
    .alu_s     (alu_s),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_ans   (alu_ans),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_op    (res_op),
    .busy      (busy),
    .op_cnt    (op_cnt)
  );

  always_comb begin
    alu_ans = '0;
    case (alu_s)
      OP_ADD: alu_ans = {2'b00, alu_a} + {2'b00, alu_b};
      OP_SUB: alu_ans = {2'b00, alu_a} - {2'b00, alu_b};
      OP_AND: alu_ans = {2'b00, alu_a & alu_b};
      OP_OR:  alu_ans = {2'b00, alu_a | alu_b};
      default: alu_ans = '0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0]  op_beat;
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
    logic [OPW-1:0] exp_op;
    logic [RW-1:0]  exp_data;
  } vec_t;

  typedef struct {
    logic [OPW-1:0] op;
    logic [RW-1:0]  data;
  } exp_t;

  exp_t            sb[$];
  int              checks;
  int              errors;
  logic [CNTW-1:0] exp_cnt;
  vec_t            vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Offer one beat and hold it until it is taken; returns at posedge+1.
  task automatic send_beat(input logic [DW-1:0] d);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout("beat_accept");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [DW-1:0] op_beat, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [OPW-1:0] exp_op,
                          input logic [RW-1:0] exp_data, input bit push);
    exp_t e;
    send_beat(op_beat);
    send_beat(a);
    if (push) begin
      e.op   = exp_op;
      e.data = exp_data;
      sb.push_back(e);
      exp_cnt = exp_cnt + 1'b1;
    end
    send_beat(b);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout("wait_idle");
    @(posedge clk);
    #1;
  endtask

  task automatic wait_res_valid();
    bit ok;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (res_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout("wait_res_valid");
  endtask

  // Idle gap with junk on in_data; operands must not move.
  task automatic gap(input logic [DW-1:0] d, input logic [DW-1:0] exp_a,
                     input logic [DW-1:0] exp_b);
    int n;
    n = int'($urandom_range(1, 3));
    in_valid = 1'b0;
    in_data  = d;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("gap_alu_a", int'(alu_a), int'(exp_a));
      chk("gap_alu_b", int'(alu_b), int'(exp_b));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    exp_t e;
    checks    = 0;
    errors    = 0;
    exp_cnt   = '0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    abort     = 1'b0;
    res_ready = 1'b1;

    vecs[0] = '{3'd1, 3'd2, 3'd5, 2'd1, 5'd29};
    vecs[1] = '{3'd1, 3'd6, 3'd2, 2'd1, 5'd4};
    vecs[2] = '{3'd5, 3'd0, 3'd7, 2'd1, 5'd25};
    vecs[3] = '{3'd2, 3'd5, 3'd3, 2'd2, 5'd1};
    vecs[4] = '{3'd7, 3'd4, 3'd1, 2'd3, 5'd5};
    vecs[5] = '{3'd0, 3'd7, 3'd1, 2'd0, 5'd8};
    vecs[6] = '{3'd4, 3'd6, 3'd6, 2'd0, 5'd12};
    vecs[7] = '{3'd6, 3'd7, 3'd6, 2'd2, 5'd6};

    fork
      forever begin
        @(negedge clk);
        if (rst_n && res_valid && res_ready && !abort) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got data %0d op %0d, expected none", res_data, res_op);
          end else begin
            e = sb.pop_front();
            chk("res_data", int'(res_data), int'(e.data));
            chk("res_op", int'(res_op), int'(e.op));
          end
        end
      end
    join_none

    // Reset values
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_op_cnt", int'(op_cnt), 0);
    chk("rst_alu_a", int'(alu_a), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // T1: add with exact latency
    begin
      exp_t t;
      send_beat(3'd0);
      send_beat(3'd3);
      t.op = OP_ADD;
      t.data = 5'd7;
      sb.push_back(t);
      exp_cnt = exp_cnt + 1'b1;
      send_beat(3'd4);
    end
    @(negedge clk);
    chk("t1_exec_res_valid", int'(res_valid), 0);
    chk("t1_exec_in_ready", int'(in_ready), 0);
    chk("t1_alu_a", int'(alu_a), 3);
    chk("t1_alu_b", int'(alu_b), 4);
    @(negedge clk);
    chk("t1_resp_res_valid", int'(res_valid), 1);
    wait_idle();
    chk("t1_op_cnt", int'(op_cnt), int'(exp_cnt));

    // Table-driven commands, back-to-back
    for (int i = 0; i < 8; i++) begin
      send_cmd(vecs[i].op_beat, vecs[i].a, vecs[i].b, vecs[i].exp_op, vecs[i].exp_data, 1);
      wait_idle();
    end
    chk("tbl_op_cnt", int'(op_cnt), int'(exp_cnt));

    // T3: back-pressure holds the result
    res_ready = 1'b0;
    send_cmd(3'd2, 3'd6, 3'd3, OP_AND, 5'd2, 1);
    wait_res_valid();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_res_valid", int'(res_valid), 1);
      chk("bp_res_data", int'(res_data), 2);
      chk("bp_in_ready", int'(in_ready), 0);
    end
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    wait_idle();
    send_cmd(3'd3, 3'd5, 3'd2, OP_OR, 5'd7, 1);
    wait_idle();

    // T4: gappy input, operands move only on handshakes
    gap(3'd7, 3'd5, 3'd2);
    send_beat(3'd0);
    gap(3'd7, 3'd5, 3'd2);
    send_beat(3'd7);
    chk("t4_alu_a", int'(alu_a), 7);
    begin
      exp_t t;
      t.op = OP_ADD;
      t.data = 5'd14;
      sb.push_back(t);
      exp_cnt = exp_cnt + 1'b1;
    end
    gap(3'd7, 3'd7, 3'd2);
    send_beat(3'd7);
    chk("t4_alu_b", int'(alu_b), 7);
    wait_idle();
    chk("t4_op_cnt", int'(op_cnt), int'(exp_cnt));

    // T5a: abort in GET_B drops the command and the offered beat
    send_beat(3'd0);
    send_beat(3'd1);
    in_valid = 1'b1;
    in_data  = 3'd5;
    abort    = 1'b1;
    @(posedge clk);
    #1;
    abort    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("abort_b_busy", int'(busy), 0);
    chk("abort_b_alu_a", int'(alu_a), 1);
    chk("abort_b_alu_b", int'(alu_b), 7);
    repeat (3) @(negedge clk);
    chk("abort_b_res_valid", int'(res_valid), 0);
    @(posedge clk);
    #1;

    // T5b: abort in RESP with res_ready high does not count
    res_ready = 1'b0;
    send_cmd(3'd0, 3'd2, 3'd2, OP_ADD, 5'd4, 0);
    wait_res_valid();
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    abort     = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_r_res_valid", int'(res_valid), 0);
    chk("abort_r_op_cnt", int'(op_cnt), int'(exp_cnt));
    chk("abort_r_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    send_cmd(3'd3, 3'd1, 3'd2, OP_OR, 5'd3, 1);
    wait_idle();
    chk("t5_op_cnt", int'(op_cnt), int'(exp_cnt));

    // T6: asynchronous reset during EXEC
    send_cmd(3'd0, 3'd1, 3'd1, OP_ADD, 5'd2, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_alu_s", int'(alu_s), 0);
    chk("arst_alu_a", int'(alu_a), 0);
    chk("arst_alu_b", int'(alu_b), 0);
    chk("arst_res_valid", int'(res_valid), 0);
    chk("arst_res_data", int'(res_data), 0);
    chk("arst_op_cnt", int'(op_cnt), 0);
    chk("arst_in_ready", int'(in_ready), 1);
    chk("arst_busy", int'(busy), 0);
    exp_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 256; i++) begin
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      a = DW'(i);
      b = DW'(i * 3);
      send_cmd(3'd0, a, b, OP_ADD, {2'b00, a} + {2'b00, b}, 1);
      wait_idle();
      if (i == 254) chk("cnt_255", int'(op_cnt), 255);
    end
    chk("cnt_wrap", int'(op_cnt), 0);
    chk("cnt_model", int'(op_cnt), int'(exp_cnt));
    chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "global timeout");
  end

endmodule
